// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_WORDS_LOG_DEF = 2;
  localparam int SET_LOG_DEF        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Helpers return full-width fields; callers truncate to the geometry in use.
  function automatic logic [29:0] get_offset(input logic [29:0] addr, input int lw);
    return addr & ((30'd1 << lw) - 30'd1);
  endfunction

  function automatic logic [29:0] get_index(input logic [29:0] addr, input int lw, input int sl);
    return (addr >> lw) & ((30'd1 << sl) - 30'd1);
  endfunction

  function automatic logic [29:0] get_tag(input logic [29:0] addr, input int lw, input int sl);
    return addr >> (lw + sl);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and instruction-memory signals of the cache bundled as one interface.
interface icache_if;

  logic        cpu_req;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_miss;
  logic        flush;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (
    output cpu_req, cpu_addr, flush, mem_rdata,
    input  cpu_rdata, cpu_miss, mem_addr
  );

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_rdata,
    output cpu_rdata, cpu_miss, mem_addr
  );

endinterface

// File: rtl/icache_fill_fsm.sv
// Line-refill sequencer: latches the missing line base, walks memory word 0 upward and
// emits the array write strobes; flush or reset abandons a partial line.
//
// state | meaning
// IDLE  | no refill in progress; a miss (without flush) starts one
// FILL  | mem_addr = {tag,index,cnt}; word cnt-1 written from mem_rdata when cnt>0
// DRAIN | last word written, tag stored and line marked valid
module icache_fill_fsm
  import icache_pkg::*;
#(
  parameter int LINE_WORDS_LOG = LINE_WORDS_LOG_DEF,
  parameter int SET_LOG        = SET_LOG_DEF,
  parameter int TAG_W          = 30 - LINE_WORDS_LOG - SET_LOG
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      flush,
  input  logic [TAG_W-1:0]          req_tag,
  input  logic [SET_LOG-1:0]        req_index,
  output logic                      busy,
  output logic                      miss_start,
  output logic [29:0]               mem_addr,
  output logic                      wr_en,
  output logic [LINE_WORDS_LOG-1:0] wr_word,
  output logic [SET_LOG-1:0]        line_index,
  output logic [TAG_W-1:0]          line_tag,
  output logic                      line_valid
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FILL  = FILL;
  localparam logic [1:0] S_DRAIN = DRAIN;

  localparam logic [LINE_WORDS_LOG-1:0] CNT_LAST = '1;

  logic [1:0]                state;
  logic [LINE_WORDS_LOG-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      line_index <= '0;
      line_tag   <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            line_tag   <= req_tag;
            line_index <= req_index;
            cnt        <= '0;
            state      <= S_FILL;
          end
        end
        S_FILL: begin
          cnt <= cnt + LINE_WORDS_LOG'(1);
          if (cnt == CNT_LAST) state <= S_DRAIN;
        end
        S_DRAIN: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign miss_start = (state == S_IDLE) && start && !flush;
  assign mem_addr   = (state == S_FILL) ? {line_tag, line_index, cnt} : 30'd0;

  // Memory data trails mem_addr by one cycle, so FILL writes the previous word.
  assign wr_en      = !flush && (((state == S_FILL) && (cnt != '0)) || (state == S_DRAIN));
  assign wr_word    = (state == S_DRAIN) ? CNT_LAST : (cnt - LINE_WORDS_LOG'(1));
  assign line_valid = (state == S_DRAIN) && !flush;

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: register arrays, combinational hit path and
// refill sequencer. Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int LINE_WORDS_LOG = LINE_WORDS_LOG_DEF,
  parameter int SET_LOG        = SET_LOG_DEF,
  parameter int TAG_W          = 30 - LINE_WORDS_LOG - SET_LOG
) (
  input  logic        clk,
  input  logic        rst_n,
  icache_if.slave     bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int WORDS = 1 << LINE_WORDS_LOG;
  localparam int SETS  = 1 << SET_LOG;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_arr  [SETS];
  logic [31:0]      data_arr [SETS*WORDS];

  logic [TAG_W-1:0]          req_tag;
  logic [SET_LOG-1:0]        req_index;
  logic [LINE_WORDS_LOG-1:0] req_offset;
  logic                      hit;

  logic                      busy;
  logic                      miss_start;
  logic                      wr_en;
  logic [LINE_WORDS_LOG-1:0] wr_word;
  logic [SET_LOG-1:0]        line_index;
  logic [TAG_W-1:0]          line_tag;
  logic                      line_valid;

  assign req_tag    = TAG_W'(get_tag(bus.cpu_addr, LINE_WORDS_LOG, SET_LOG));
  assign req_index  = SET_LOG'(get_index(bus.cpu_addr, LINE_WORDS_LOG, SET_LOG));
  assign req_offset = LINE_WORDS_LOG'(get_offset(bus.cpu_addr, LINE_WORDS_LOG));

  assign hit           = bus.cpu_req && valid[req_index] && (tag_arr[req_index] == req_tag);
  assign bus.cpu_rdata = data_arr[{req_index, req_offset}];
  assign bus.cpu_miss  = busy || (bus.cpu_req && !hit);

  icache_fill_fsm #(
    .LINE_WORDS_LOG (LINE_WORDS_LOG),
    .SET_LOG        (SET_LOG),
    .TAG_W          (TAG_W)
  ) u_fill_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (bus.cpu_req && !hit),
    .flush      (bus.flush),
    .req_tag    (req_tag),
    .req_index  (req_index),
    .busy       (busy),
    .miss_start (miss_start),
    .mem_addr   (bus.mem_addr),
    .wr_en      (wr_en),
    .wr_word    (wr_word),
    .line_index (line_index),
    .line_tag   (line_tag),
    .line_valid (line_valid)
  );

  // Flush clears every line at once and overrides a same-cycle validate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (bus.flush) begin
      valid <= '0;
    end else if (line_valid) begin
      valid[line_index] <= 1'b1;
    end
  end

  // Tag and data storage carries no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_valid) tag_arr[line_index] <= line_tag;
    if (wr_en) data_arr[{line_index, wr_word}] <= bus.mem_rdata;
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (!busy && hit) hit_cnt <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: directed accesses with literal checks plus a per-cycle
// comparison against a line-level cache model. Build with ICACHE_PERF_CNT_EN to cover the counters.
module tb_icache_direct_mapped;

  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en_cmp = 1'b0;
  int   checks = 0;
  int   errors = 0;

  icache_if bus();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_direct_mapped dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: registered read, data encodes its own word address.
  always @(posedge clk) bus.mem_rdata <= 32'hA000_0000 | {2'b00, bus.mem_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-set valid/tag plus the position inside the current refill
  // (0 idle, 1..WORDS memory-read cycles, WORDS+1 the final write cycle).
  bit   [7:0]  m_valid;
  logic [24:0] m_tag [8];
  int          m_fill = 0;
  logic [29:0] m_base;
  int unsigned m_hits = 0;
  int unsigned m_misses = 0;

  always @(negedge clk) begin : model
    logic [29:0] a;
    int          idx;
    logic        m_hit;
    logic        exp_miss;
    logic [29:0] exp_mem;
    a        = bus.cpu_addr;
    idx      = int'(a[4:2]);
    m_hit    = bus.cpu_req && m_valid[idx] && (m_tag[idx] == a[29:5]);
    exp_miss = (m_fill != 0) || (bus.cpu_req && !m_hit);
    exp_mem  = (m_fill >= 1 && m_fill <= WORDS) ? m_base + 30'(m_fill - 1) : 30'd0;
    if (en_cmp) begin
      chk("model_miss", {31'd0, bus.cpu_miss}, {31'd0, exp_miss});
      chk("model_mem_addr", {2'b00, bus.mem_addr}, {2'b00, exp_mem});
      if (bus.cpu_req && !exp_miss)
        chk("model_rdata", bus.cpu_rdata, 32'hA000_0000 | {2'b00, a});
`ifdef ICACHE_PERF_CNT_EN
      chk("model_hit_cnt", hit_cnt, m_hits);
      chk("model_miss_cnt", miss_cnt, m_misses);
`endif
    end
    if (!rst_n) begin
      m_fill = 0; m_valid = '0; m_hits = 0; m_misses = 0;
    end else begin
      if (m_fill == 0 && m_hit) m_hits++;
      if (bus.flush) begin
        m_fill = 0; m_valid = '0;
      end else if (m_fill == 0) begin
        if (bus.cpu_req && !m_hit) begin
          m_fill = 1; m_base = {a[29:2], 2'b00}; m_misses++;
        end
      end else if (m_fill == WORDS + 1) begin
        m_valid[int'(m_base[4:2])] = 1'b1;
        m_tag[int'(m_base[4:2])]   = m_base[29:5];
        m_fill = 0;
      end else begin
        m_fill++;
      end
    end
  end

  task automatic drive(input logic r, input logic [29:0] a, input logic f, input logic rn);
    @(posedge clk); #1;
    bus.cpu_req = r; bus.cpu_addr = a; bus.flush = f; rst_n = rn;
    #1;
  endtask

  // Holds a request until it hits; lat = cycles spent stalled after the first one.
  task automatic access(input logic [29:0] a, output int lat);
    lat = 0;
    drive(1'b1, a, 1'b0, 1'b1);
    while (bus.cpu_miss && lat < 20) begin
      lat++;
      drive(1'b1, a, 1'b0, 1'b1);
    end
    if (bus.cpu_miss) chk("access_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
    drive(1'b0, 30'h0, 1'b0, 1'b0);
    drive(1'b0, 30'h0, 1'b0, 1'b0);
    chk("rst_miss_noreq", {31'd0, bus.cpu_miss}, 32'd0);
    chk("rst_mem_addr", {2'b00, bus.mem_addr}, 32'd0);
    drive(1'b1, 30'h0, 1'b0, 1'b0);
    chk("rst_miss_eq_req", {31'd0, bus.cpu_miss}, 32'd1);
    en_cmp = 1'b1;

    // cold miss on word 0
    drive(1'b1, 30'h0, 1'b0, 1'b1);
    chk("cold_c0_miss", {31'd0, bus.cpu_miss}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 30'h0, 1'b0, 1'b1);
      chk("cold_mem_addr", {2'b00, bus.mem_addr}, 32'(k - 1));
      chk("cold_fill_miss", {31'd0, bus.cpu_miss}, 32'd1);
    end
    drive(1'b1, 30'h0, 1'b0, 1'b1);
    chk("cold_c5_miss", {31'd0, bus.cpu_miss}, 32'd1);
    chk("cold_c5_mem_addr", {2'b00, bus.mem_addr}, 32'd0);
    drive(1'b1, 30'h0, 1'b0, 1'b1);
    chk("cold_c6_miss", {31'd0, bus.cpu_miss}, 32'd0);
    chk("cold_c6_rdata", bus.cpu_rdata, 32'hA000_0000);

    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 30'(k), 1'b0, 1'b1);
      chk("line_hit_miss", {31'd0, bus.cpu_miss}, 32'd0);
      chk("line_hit_rdata", bus.cpu_rdata, 32'hA000_0000 | 32'(k));
      chk("line_hit_mem_addr", {2'b00, bus.mem_addr}, 32'd0);
    end
    drive(1'b0, 30'h0, 1'b0, 1'b1);
`ifdef ICACHE_PERF_CNT_EN
    chk("perf_hit_cnt", hit_cnt, 32'd4);
    chk("perf_miss_cnt", miss_cnt, 32'd1);
`endif

    // conflict on set 0
    access(30'h20, lat);
    chk("conflict_lat", 32'(lat), 32'd6);
    chk("conflict_rdata", bus.cpu_rdata, 32'hA000_0020);
    access(30'h0, lat);
    chk("reaccess_lat", 32'(lat), 32'd6);

    // flush in idle invalidates
    access(30'h0, lat);
    chk("hit_lat", 32'(lat), 32'd0);
    drive(1'b0, 30'h0, 1'b1, 1'b1);
    access(30'h0, lat);
    chk("flush_refill_lat", 32'(lat), 32'd6);

    // flush aborts a fill
    drive(1'b1, 30'h40, 1'b0, 1'b1);
    drive(1'b1, 30'h40, 1'b0, 1'b1);
    drive(1'b1, 30'h40, 1'b0, 1'b1);
    drive(1'b1, 30'h40, 1'b1, 1'b1);
    drive(1'b1, 30'h40, 1'b0, 1'b1);
    chk("abort_idle_mem_addr", {2'b00, bus.mem_addr}, 32'd0);
    chk("abort_idle_miss", {31'd0, bus.cpu_miss}, 32'd1);
    drive(1'b1, 30'h40, 1'b0, 1'b1);
    chk("abort_refill_w0", {2'b00, bus.mem_addr}, 32'h40);
    access(30'h40, lat);
    chk("abort_rdata", bus.cpu_rdata, 32'hA000_0040);

    // flush coinciding with the drain write
    for (int k = 0; k <= 4; k++) drive(1'b1, 30'h60, 1'b0, 1'b1);
    drive(1'b1, 30'h60, 1'b1, 1'b1);
    chk("drain_flush_c5_miss", {31'd0, bus.cpu_miss}, 32'd1);
    drive(1'b1, 30'h60, 1'b0, 1'b1);
    chk("drain_flush_miss", {31'd0, bus.cpu_miss}, 32'd1);
    chk("drain_flush_mem_addr", {2'b00, bus.mem_addr}, 32'd0);
    access(30'h60, lat);
    chk("drain_flush_lat", 32'(lat), 32'd5);

    // flush holds off a pending miss
    drive(1'b1, 30'h84, 1'b1, 1'b1);
    chk("flush_pending_miss", {31'd0, bus.cpu_miss}, 32'd1);
    drive(1'b1, 30'h84, 1'b0, 1'b1);
    chk("flush_pending_mem_addr", {2'b00, bus.mem_addr}, 32'd0);
    drive(1'b1, 30'h84, 1'b0, 1'b1);
    chk("flush_pending_w0", {2'b00, bus.mem_addr}, 32'h84);
    access(30'h84, lat);
    chk("flush_pending_rdata", bus.cpu_rdata, 32'hA000_0084);

    // reset while FILL is at cnt=2
    drive(1'b1, 30'h100, 1'b0, 1'b1);
    drive(1'b1, 30'h100, 1'b0, 1'b1);
    drive(1'b1, 30'h100, 1'b0, 1'b1);
    drive(1'b1, 30'h100, 1'b0, 1'b0);
    chk("rst_mid_cnt2_mem_addr", {2'b00, bus.mem_addr}, 32'h102);
    drive(1'b1, 30'h100, 1'b0, 1'b1);
    chk("rst_mid_mem_addr", {2'b00, bus.mem_addr}, 32'd0);
    chk("rst_mid_miss", {31'd0, bus.cpu_miss}, 32'd1);
    drive(1'b1, 30'h100, 1'b0, 1'b1);
    chk("rst_refill_w0", {2'b00, bus.mem_addr}, 32'h100);
    access(30'h100, lat);
    chk("rst_refill_rdata", bus.cpu_rdata, 32'hA000_0100);
    access(30'h85, lat);
    chk("rst_invalidated_lat", 32'(lat), 32'd6);
    chk("rst_invalidated_rdata", bus.cpu_rdata, 32'hA000_0085);

    drive(1'b0, 30'h0, 1'b0, 1'b1);
    drive(1'b0, 30'h0, 1'b0, 1'b1);
    en_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
